fb_master_delay_meas: RTL and testbench
=======================================

# fb_master_delay_meas

Master-side link delay measurement engine for the FreeDM bus, running in the 100 MHz domain. It times the interval from the master starting a delay-measurement frame (TX enable rising) to the first returning nibble (RX data valid rising). It then subtracts the slave's self-reported logic delay, which is carried back in the frame's delay field, and halves the remainder. The result is the one-way cable/PHY delay, which the master distributes to slaves in the delay-distribution field.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16'd50000, maximum Clk_100MHz cycles spent in any waiting state before abort; legal range 2..65535.

Ports:
- Clk_100MHz  in  1  measurement clock.
- Reset  in  1  asynchronous, active-high.
- StartMeas  in  1  single-cycle request, Clk_100MHz domain.
- MTxEn  in  1  master transmit enable, MII TX domain (asynchronous here).
- MRxDV  in  1  master receive data valid, MII RX domain (asynchronous here).
- SlaveLogicDelay  in  8  slave logic delay, in 100 MHz cycles, MII RX domain. Must be stable from at least 4 Clk_100MHz cycles before SlaveLdValid rises until SlaveLdValid falls.
- SlaveLdValid  in  1  level, high while SlaveLogicDelay is valid, MII RX domain.
- MeasBusy  out  1  high in any state other than IDLE.
- MeasDone  out  1  one-cycle pulse when new results are registered.
- MeasTimeout  out  1  one-cycle pulse on abort.
- MeasUnderflow  out  1  registered with the results; set when round trip < SlaveLogicDelay.
- RoundTripCnt  out  16  last measured round trip, in cycles.
- LinkDelay  out  16  last computed one-way delay, in cycles.

## Operation
- Synchronizers: MTxEn, MRxDV and SlaveLdValid each pass through a 3-flop chain (Sync1, Sync2, Sync3).
  - A rising edge is detected when Sync2=1 and Sync3=0.
  - All three paths have equal depth, so synchronizer latency cancels out of the measured interval.
- States: IDLE, ARM, COUNT, WAIT_LD, CALC, DONE.
- IDLE: StartMeas=1 -> ARM. The timeout counter is cleared on every state entry.
- ARM: waits for the MTxEn edge.
  - On the edge, the interval counter is loaded with 1 and the FSM goes to COUNT.
  - An MTxEn level that is already high does not qualify; only an edge does.
- COUNT: the interval counter increments by 1 per cycle.
  - On the MRxDV edge, the counter value is latched into an internal round-trip register and the FSM goes to WAIT_LD.
  - If the MTxEn and MRxDV edges are detected in the same cycle while in ARM, only the TX edge is taken.
- WAIT_LD: on the SlaveLdValid edge, SlaveLogicDelay is sampled and the FSM goes to CALC.
- CALC: one cycle.
  - Diff = round-trip − {8'd0, SlaveLogicDelay}, computed 17 bits wide.
  - If Diff < 0, the result is 0 and the underflow flag is set.
  - Otherwise the result is Diff[15:1], which truncates toward zero.
- DONE: RoundTripCnt, LinkDelay and MeasUnderflow update together; MeasDone=1 for this one cycle; next state is IDLE.
- Timeout: in ARM, COUNT or WAIT_LD, the timeout counter reaching TIMEOUT_CYCLES−1 causes the following.
  - MeasTimeout pulses for one cycle.
  - The FSM returns to IDLE.
  - RoundTripCnt, LinkDelay and MeasUnderflow keep their previous values.
- The interval counter saturates at 16'hFFFF and never wraps.
- StartMeas is ignored whenever MeasBusy=1.
- Reset at any time, including mid-measurement:
  - FSM goes to IDLE.
  - All synchronizers and counters clear.
  - All outputs are 0: MeasBusy, MeasDone, MeasTimeout, MeasUnderflow = 0; RoundTripCnt, LinkDelay = 16'h0.

## Timing
- StartMeas at cycle t -> MeasBusy=1 at t+1.
- Interval definition: if the TX edge detect fires at cycle T and the RX edge detect fires at cycle T+N, then RoundTripCnt = N.
- Asynchronous input to edge detect: 2–3 Clk_100MHz cycles.
- SlaveLdValid edge detect at cycle S:
  - CALC is at S+1.
  - DONE/MeasDone is at S+2.
  - Outputs are visible from S+3.
  - MeasBusy=0 from S+3.
- Output registers change only in the DONE cycle or on Reset.
- A new StartMeas is accepted in the first cycle after DONE or after a timeout.

## Test plan
- Nominal measurement:
  - Stimulus: StartMeas; MTxEn rises; MRxDV rises 200 cycles later (synchronous to Clk_100MHz); SlaveLogicDelay=40 with SlaveLdValid.
  - Required: RoundTripCnt=200, LinkDelay=80, MeasUnderflow=0, a single MeasDone pulse.
- Odd difference: round trip 201, SlaveLogicDelay=40 -> LinkDelay=80.
- Underflow: round trip 30, SlaveLogicDelay=40 -> LinkDelay=0, MeasUnderflow=1, MeasDone pulses.
- Timeout, with TIMEOUT_CYCLES=100:
  - Stimulus: StartMeas; MTxEn edge; MRxDV never rises.
  - Required: MeasTimeout pulses 100 cycles after COUNT entry; previous results are held; MeasBusy drops.
- Ignored start and mid-operation reset:
  - A second StartMeas while in COUNT has no effect.
  - Reset asserted in COUNT -> all outputs 0.
  - The next full measurement after reset gives correct values.
- Pre-high TX: MTxEn already high at StartMeas -> stays in ARM until MTxEn falls and rises again.

Source files
------------

// File: rtl/fb_master_delay_meas.sv
// fb_master_delay_meas
//   Master-side FreeDM link delay measurement. Times the interval from the
//   MTxEn rising edge to the MRxDV rising edge. It then subtracts the
//   slave-reported logic delay and halves the remainder, which gives the
//   one-way cable/PHY delay.
// Ports:
//   Clk_100MHz, Reset  clock and asynchronous active-high reset.
//   StartMeas          single-cycle measurement request, ignored while busy.
//   MTxEn, MRxDV       asynchronous MII enables, synchronized here.
//   SlaveLogicDelay    slave logic delay in 100 MHz cycles.
//                      Quasi-static while SlaveLdValid is high.
//   SlaveLdValid       asynchronous level qualifying SlaveLogicDelay.
//   MeasBusy           high outside IDLE.
//   MeasDone           one-cycle pulse when new results are registered.
//   MeasTimeout        one-cycle pulse on abort.
//   MeasUnderflow      round trip was shorter than the slave logic delay.
//   RoundTripCnt       last measured round trip in cycles.
//   LinkDelay          last computed one-way delay in cycles.
module fb_master_delay_meas #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        Clk_100MHz,
  input  logic        Reset,
  input  logic        StartMeas,
  input  logic        MTxEn,
  input  logic        MRxDV,
  input  logic [7:0]  SlaveLogicDelay,
  input  logic        SlaveLdValid,
  output logic        MeasBusy,
  output logic        MeasDone,
  output logic        MeasTimeout,
  output logic        MeasUnderflow,
  output logic [15:0] RoundTripCnt,
  output logic [15:0] LinkDelay
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_COUNT, S_WAIT_LD, S_CALC, S_DONE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_tx_sync;
  logic [2:0]  r_rx_sync;
  logic [2:0]  r_ld_sync;
  logic [15:0] r_to_cnt;
  logic [15:0] r_int_cnt;
  logic [15:0] r_rt;
  logic [7:0]  r_ld;
  logic [15:0] r_link_calc;
  logic        r_uf_calc;
  logic        r_busy;
  logic        r_done;
  logic        r_timeout;
  logic        r_uf;
  logic [15:0] r_rt_out;
  logic [15:0] r_link_out;

  logic        w_tx_edge;
  logic        w_rx_edge;
  logic        w_ld_edge;
  logic        w_to_hit;
  logic [16:0] w_diff;

  // Equal-depth chains on every path, so synchronizer latency cancels out of the interval.
  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      r_tx_sync <= '0;
      r_rx_sync <= '0;
      r_ld_sync <= '0;
    end else begin
      r_tx_sync <= {r_tx_sync[1:0], MTxEn};
      r_rx_sync <= {r_rx_sync[1:0], MRxDV};
      r_ld_sync <= {r_ld_sync[1:0], SlaveLdValid};
    end
  end

  assign w_tx_edge = r_tx_sync[1] & ~r_tx_sync[2];
  assign w_rx_edge = r_rx_sync[1] & ~r_rx_sync[2];
  assign w_ld_edge = r_ld_sync[1] & ~r_ld_sync[2];
  assign w_to_hit  = (r_to_cnt == TIMEOUT_CYCLES - 16'd1);
  // Bit 16 set means the round trip was shorter than the slave delay.
  assign w_diff    = {1'b0, r_rt} - {9'd0, r_ld};

  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_to_cnt    <= '0;
      r_int_cnt   <= '0;
      r_rt        <= '0;
      r_ld        <= '0;
      r_link_calc <= '0;
      r_uf_calc   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_uf        <= 1'b0;
      r_rt_out    <= '0;
      r_link_out  <= '0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_to_cnt <= '0;
          if (StartMeas) begin
            r_state <= S_ARM;
            r_busy  <= 1'b1;
          end
        end
        S_ARM, S_COUNT, S_WAIT_LD: begin
          if (r_state == S_COUNT && r_int_cnt != 16'hFFFF)
            r_int_cnt <= r_int_cnt + 16'd1;
          if (w_to_hit) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_to_cnt  <= '0;
          end else if (r_state == S_ARM && w_tx_edge) begin
            r_int_cnt <= 16'd1;
            r_state   <= S_COUNT;
            r_to_cnt  <= '0;
          end else if (r_state == S_COUNT && w_rx_edge) begin
            r_rt     <= r_int_cnt;
            r_state  <= S_WAIT_LD;
            r_to_cnt <= '0;
          end else if (r_state == S_WAIT_LD && w_ld_edge) begin
            r_ld     <= SlaveLogicDelay;
            r_state  <= S_CALC;
            r_to_cnt <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end
        S_CALC: begin
          r_uf_calc   <= w_diff[16];
          r_link_calc <= w_diff[16] ? '0 : {1'b0, w_diff[15:1]};
          r_state     <= S_DONE;
          r_done      <= 1'b1;
          r_to_cnt    <= '0;
        end
        S_DONE: begin
          r_rt_out   <= r_rt;
          r_link_out <= r_link_calc;
          r_uf       <= r_uf_calc;
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_to_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign MeasBusy      = r_busy;
  assign MeasDone      = r_done;
  assign MeasTimeout   = r_timeout;
  assign MeasUnderflow = r_uf;
  assign RoundTripCnt  = r_rt_out;
  assign LinkDelay     = r_link_out;

endmodule

// File: tb/tb_fb_master_delay_meas.sv
module tb_fb_master_delay_meas;

  localparam int unsigned TO = 250;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        txen;
  logic        rxdv;
  logic [7:0]  sld;
  logic        ldv;
  logic        busy;
  logic        done;
  logic        tmo;
  logic        uf;
  logic [15:0] rtc;
  logic [15:0] lnk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] rt;
    logic [15:0] ld;
    logic        uf;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  fb_master_delay_meas #(.TIMEOUT_CYCLES(16'(TO))) u_dut (
    .Clk_100MHz     (clk),
    .Reset          (rst),
    .StartMeas      (start),
    .MTxEn          (txen),
    .MRxDV          (rxdv),
    .SlaveLogicDelay(sld),
    .SlaveLdValid   (ldv),
    .MeasBusy       (busy),
    .MeasDone       (done),
    .MeasTimeout    (tmo),
    .MeasUnderflow  (uf),
    .RoundTripCnt   (rtc),
    .LinkDelay      (lnk)
  );

  always #5 clk = ~clk;

  task automatic drv_tick;
    @(posedge clk);
    #2;
  endtask

  task automatic smp_tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int unsigned rt, input int unsigned ld);
    exp_t e;
    e.rt = 16'(rt);
    if (rt < ld) begin
      e.ld = 16'd0;
      e.uf = 1'b1;
    end else begin
      e.ld = 16'((rt - ld) / 2);
      e.uf = 1'b0;
    end
    return e;
  endfunction

  // One full measurement: round trip rt cycles, slave delay ld.
  task automatic run_meas(input int unsigned rt, input int unsigned ld,
                          input bit pretx, input bit dup_start);
    exp_t e;
    int   lat;
    sb.push_back(model(rt, ld));
    sld = 8'(ld);
    if (pretx) begin
      txen = 1'b1;
      repeat (6) drv_tick();
    end
    drv_tick();
    start = 1'b1;
    smp_tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rise: got %b expected 1", busy);
    end
    #1 start = 1'b0;
    if (pretx) begin
      repeat (20) drv_tick();
      n_checks++;
      if ({busy, done} !== 2'b10) begin
        n_fail++;
        $display("FAIL pretx_hold: got busy=%b done=%b expected busy=1 done=0", busy, done);
      end
      txen = 1'b0;
      repeat (5) drv_tick();
    end
    repeat (3) drv_tick();
    txen = 1'b1;
    for (int i = 0; i < int'(rt); i++) begin
      drv_tick();
      start = (dup_start && i == int'(rt) / 2);
    end
    start = 1'b0;
    rxdv  = 1'b1;
    repeat (6) drv_tick();
    ldv = 1'b1;
    lat = 0;
    do begin
      smp_tick();
      lat++;
    end while (done !== 1'b1 && lat < 50);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_wait: got no MeasDone within %0d cycles expected pulse", lat);
    end
    n_checks++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL done_latency: got %0d expected 4", lat);
    end
    n_checks++;
    if (rtc !== last.rt || lnk !== last.ld) begin
      n_fail++;
      $display("FAIL hold_until_done: got rt=%0d ld=%0d expected rt=%0d ld=%0d",
               rtc, lnk, last.rt, last.ld);
    end
    e = sb.pop_front();
    smp_tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_single: got done=%b busy=%b expected 0 0", done, busy);
    end
    n_checks++;
    if (rtc !== e.rt) begin
      n_fail++;
      $display("FAIL round_trip: got %0d expected %0d", rtc, e.rt);
    end
    n_checks++;
    if (lnk !== e.ld) begin
      n_fail++;
      $display("FAIL link_delay: got %0d expected %0d", lnk, e.ld);
    end
    n_checks++;
    if (uf !== e.uf) begin
      n_fail++;
      $display("FAIL underflow: got %b expected %b", uf, e.uf);
    end
    last = e;
    #1;
    txen = 1'b0;
    rxdv = 1'b0;
    ldv  = 1'b0;
    repeat (6) drv_tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; txen = 1'b0; rxdv = 1'b0; ldv = 1'b0; sld = 8'd0;
    last = '0;
    repeat (3) drv_tick();
    n_checks++;
    if ({busy, done, tmo, uf, rtc, lnk} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b tmo=%b uf=%b rt=%0d ld=%0d expected all 0",
               busy, done, tmo, uf, rtc, lnk);
    end
    rst = 1'b0;
    repeat (3) drv_tick();
  endtask

  task automatic test_nominal;     run_meas(200, 40, 1'b0, 1'b0); endtask
  task automatic test_odd;         run_meas(201, 40, 1'b0, 1'b0); endtask
  task automatic test_underflow;   run_meas(30,  40, 1'b0, 1'b0); endtask
  task automatic test_equal;       run_meas(40,  40, 1'b0, 1'b0); endtask
  task automatic test_ignored_start; run_meas(150, 20, 1'b0, 1'b1); endtask
  task automatic test_pretx;       run_meas(100, 10, 1'b1, 1'b0); endtask

  task automatic test_timeout;
    int  n;
    bit  saw_done;
    drv_tick();
    start = 1'b1;
    smp_tick();
    #1 start = 1'b0;
    repeat (3) drv_tick();
    txen = 1'b1;
    n = 0;
    saw_done = 1'b0;
    do begin
      smp_tick();
      n++;
      if (done === 1'b1) saw_done = 1'b1;
    end while (tmo !== 1'b1 && n < int'(TO) + 20);
    n_checks++;
    if (n != int'(TO) + 3 || tmo !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_time: got pulse=%b after %0d cycles expected pulse after %0d",
               tmo, n, TO + 3);
    end
    n_checks++;
    if (busy !== 1'b0 || saw_done) begin
      n_fail++;
      $display("FAIL timeout_busy: got busy=%b done_seen=%b expected 0 0", busy, saw_done);
    end
    n_checks++;
    if (rtc !== last.rt || lnk !== last.ld || uf !== last.uf) begin
      n_fail++;
      $display("FAIL timeout_hold: got rt=%0d ld=%0d uf=%b expected rt=%0d ld=%0d uf=%b",
               rtc, lnk, uf, last.rt, last.ld, last.uf);
    end
    smp_tick();
    n_checks++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: got %b expected 0", tmo);
    end
    #1 txen = 1'b0;
    repeat (6) drv_tick();
  endtask

  task automatic test_mid_reset;
    drv_tick();
    start = 1'b1;
    drv_tick();
    start = 1'b0;
    repeat (3) drv_tick();
    txen = 1'b1;
    repeat (20) drv_tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, tmo, uf, rtc, lnk} !== 36'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b done=%b tmo=%b uf=%b rt=%0d ld=%0d expected all 0",
               busy, done, tmo, uf, rtc, lnk);
    end
    last = '0;
    drv_tick();
    rst  = 1'b0;
    txen = 1'b0;
    repeat (6) drv_tick();
    run_meas(200, 40, 1'b0, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal();
    test_odd();
    test_underflow();
    test_equal();
    test_ignored_start();
    test_pretx();
    test_timeout();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
